// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per clock.
// Divider datapath is present only when MDU_DIV_EN is defined; otherwise ops 4-7 return 0 on the fast path.
module mdu_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);
  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d, op_in;
  logic [CW-1:0]     count_q, count_d;
  logic [4:0]        rd_q, rd_d, rdo_q, rdo_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   opd_q, opd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              signed_a, signed_b, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, acc_next, prod;
  logic [XLEN-1:0]   fix_res;
`ifdef MDU_DIV_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  logic [XLEN:0]     div_rs;
  logic [XLEN-1:0]   div_diff, div_val;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
`endif

  assign op_in = op_e'(op_i);

  always_comb begin
    if (op_i[2]) begin
      signed_a = !op_i[0];
      signed_b = !op_i[0];
    end else begin
      signed_a = (op_in != OP_MULHU);
      signed_b = !op_i[1];
    end
    a_neg = signed_a & a_i[XLEN-1];
    b_neg = signed_b & b_i[XLEN-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
  end

  // acc holds {hi product, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    acc_next = mul_next;
    prod     = neg_q ? -acc_next : acc_next;
    fix_res  = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
    div_rs   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_rs[XLEN-1:0] - opd_q;
    div_ge   = (div_rs >= {1'b0, opd_q});
    div_next = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                      : {div_rs[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    if (op_q[2]) begin
      acc_next = div_next;
      div_val  = op_q[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
      fix_res  = neg_q ? -div_val : div_val;
    end else begin
      div_val  = '0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    count_d = count_q;
    rd_d    = rd_q;
    rdo_d   = rdo_q;
    neg_d   = neg_q;
    opd_d   = opd_q;
    acc_d   = acc_q;
    res_d   = res_q;
    if (flush_i) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: if (start_i) begin
          op_d    = op_in;
          rd_d    = rd_i;
          count_d = '0;
          if (op_i[2]) begin
`ifdef MDU_DIV_EN
            if (b_i == '0) begin
              state_d = DONE;
              rdo_d   = rd_i;
              res_d   = op_i[1] ? a_i : '1;
            end else if (!op_i[0] && a_i == MIN_NEG && b_i == '1) begin
              state_d = DONE;
              rdo_d   = rd_i;
              res_d   = op_i[1] ? '0 : MIN_NEG;
            end else begin
              state_d = CALC;
              acc_d   = {{XLEN{1'b0}}, a_mag};
              opd_d   = b_mag;
              neg_d   = op_i[1] ? a_neg : (a_neg ^ b_neg);
            end
`else
            state_d = DONE;
            rdo_d   = rd_i;
            res_d   = '0;
`endif
          end else begin
            state_d = CALC;
            acc_d   = {{XLEN{1'b0}}, b_mag};
            opd_d   = a_mag;
            neg_d   = a_neg ^ b_neg;
          end
        end
        CALC: begin
          acc_d   = acc_next;
          count_d = count_q + CW'(1);
          if (count_q == '1) begin
            state_d = DONE;
            count_d = '0;
            res_d   = fix_res;
            rdo_d   = rd_q;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      count_q <= '0;
      rd_q    <= '0;
      rdo_q   <= '0;
      neg_q   <= 1'b0;
      opd_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      rdo_q   <= rdo_d;
      neg_q   <= neg_d;
      opd_q   <= opd_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = res_q;
  assign rd_o     = rdo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter; divide expectations follow MDU_DIV_EN.
module tb_mdu_iter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [4:0]  rd_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  localparam int NORM = 32;
  localparam int FAST = 0;

  mdu_iter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .rd_i(rd_i), .flush_i(flush_i), .busy_o(busy_o), .valid_o(valid_o),
    .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from idle; optionally hammer start_i with another op while busy.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input int exp_lat, input bit interfere);
    int lat;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b; rd_i = rd;
    step();
    start_i = 1'b0; a_i = $urandom; b_i = $urandom; rd_i = 5'd31;
    check_eq({tag, ".busy"}, {31'b0, busy_o}, 32'd1);
    lat = 0;
    while (!valid_o && lat < 40) begin
      if (interfere && lat >= 3 && lat <= 6) begin
        start_i = 1'b1; op_i = 3'd3; a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF; rd_i = 5'd9;
      end else begin
        start_i = 1'b0;
      end
      step();
      lat++;
    end
    start_i = 1'b0;
    check_eq({tag, ".lat"}, lat, exp_lat);
    check_eq({tag, ".res"}, result_o, exp);
    check_eq({tag, ".rd"}, {27'b0, rd_o}, {27'b0, rd});
    step();
    check_eq({tag, ".idle"}, {30'b0, busy_o, valid_o}, 32'd0);
    check_eq({tag, ".hold"}, result_o, exp);
  endtask

  initial begin
    int nvalid;
    #12;
    check_eq("reset", {busy_o, valid_o, rd_o, result_o[24:0]}, 32'd0);
    rst = 1'b1;
    step();

    do_op("mul_7_m3",   3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, NORM, 1'b0);
    do_op("mulhu_ff",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, NORM, 1'b0);
    do_op("mulh_ff",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, NORM, 1'b0);
    do_op("mulhsu_m1",  3'd2, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, NORM, 1'b0);
    do_op("mulhu_min",  3'd3, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000, NORM, 1'b0);
    do_op("mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd11, 32'h4000_0000, NORM, 1'b0);
    do_op("mul_wrap",   3'd0, 32'h0001_0000, 32'h0001_0000, 5'd12, 32'h0000_0000, NORM, 1'b0);
    do_op("mul_rd0",    3'd0, 32'd3,         32'd5,         5'd0,  32'd15,        NORM, 1'b0);
`ifdef MDU_DIV_EN
    do_op("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2,         5'd13, 32'hFFFF_FFFD, NORM, 1'b0);
    do_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2,         5'd14, 32'hFFFF_FFFF, NORM, 1'b0);
    do_op("div_7_m2",   3'd4, 32'd7,         32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFD, NORM, 1'b0);
    do_op("rem_7_m2",   3'd6, 32'd7,         32'hFFFF_FFFE, 5'd16, 32'd1,         NORM, 1'b0);
    do_op("divu_100_7", 3'd5, 32'd100,       32'd7,         5'd17, 32'd14,        NORM, 1'b0);
    do_op("remu_100_7", 3'd7, 32'd100,       32'd7,         5'd18, 32'd2,         NORM, 1'b0);
    do_op("divu_big",   3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0,         NORM, 1'b0);
    do_op("remu_big",   3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, NORM, 1'b0);
    do_op("div_by0",    3'd4, 32'd5,         32'd0,         5'd21, 32'hFFFF_FFFF, FAST, 1'b0);
    do_op("rem_by0",    3'd6, 32'd5,         32'd0,         5'd22, 32'd5,         FAST, 1'b0);
    do_op("divu_by0",   3'd5, 32'd5,         32'd0,         5'd23, 32'hFFFF_FFFF, FAST, 1'b0);
    do_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd24, 32'h8000_0000, FAST, 1'b0);
    do_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd25, 32'd0,         FAST, 1'b0);
`else
    do_op("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2,         5'd13, 32'd0, FAST, 1'b0);
    do_op("mul_nz",     3'd0, 32'd6,         32'd7,         5'd3,  32'd42, NORM, 1'b0);
    do_op("remu_100_7", 3'd7, 32'd100,       32'd7,         5'd18, 32'd0, FAST, 1'b0);
    do_op("div_by0",    3'd4, 32'd5,         32'd0,         5'd21, 32'd0, FAST, 1'b0);
    do_op("mul_nz2",    3'd0, 32'd2,         32'd9,         5'd4,  32'd18, NORM, 1'b0);
    do_op("rem_by0",    3'd6, 32'd5,         32'd0,         5'd22, 32'd0, FAST, 1'b0);
    do_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd24, 32'd0, FAST, 1'b0);
`endif

    do_op("busy_ign",   3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, NORM, 1'b1);

    // flush at count 10 of a multiply, then a fresh op must run normally
    start_i = 1'b1; op_i = 3'd0; a_i = 32'd9; b_i = 32'd9; rd_i = 5'd2;
    step();
    start_i = 1'b0;
    repeat (10) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check_eq("flush.idle", {30'b0, busy_o, valid_o}, 32'd0);
    do_op("after_flush", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, NORM, 1'b0);

    flush_i = 1'b1; start_i = 1'b1; op_i = 3'd0; a_i = 32'd1; b_i = 32'd1; rd_i = 5'd1;
    step();
    flush_i = 1'b0; start_i = 1'b0;
    check_eq("flush_start", {30'b0, busy_o, valid_o}, 32'd0);

    // asynchronous reset at count 20 clears everything immediately
    start_i = 1'b1; op_i = 3'd0; a_i = 32'd7; b_i = 32'd7; rd_i = 5'd7;
    step();
    start_i = 1'b0;
    repeat (20) step();
    rst = 1'b0;
    #1;
    check_eq("rst.ctl", {30'b0, busy_o, valid_o}, 32'd0);
    check_eq("rst.res", result_o, 32'd0);
    check_eq("rst.rd", {27'b0, rd_o}, 32'd0);
    step();
    #2 rst = 1'b1;
    nvalid = 0;
    repeat (40) begin
      step();
      if (valid_o) nvalid++;
    end
    check_eq("rst.novalid", nvalid, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative 32-bit multiply/divide unit implementing the RV32M operations. Sits between register-file read and writeback: operands arrive from the register file's two read ports, and the result plus destination index go back to the register file's write port (valid pulse drives write enable). One operation in flight; shift-add multiply and restoring divide, one bit per clock.

## Interface
- XLEN, 32, operand/result width (only 32 supported)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start_i  in  1  request; accepted only when busy_o=0
- op_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- a_i  in  32  operand A (rs1 value)
- b_i  in  32  operand B (rs2 value)
- rd_i  in  5  destination register index, carried to rd_o
- flush_i  in  1  synchronous abort of operation in flight
- busy_o  out  1  unit occupied; start_i ignored
- valid_o  out  1  one-cycle result pulse (write enable to register file)
- result_o  out  32  result, stable while valid_o=1
- rd_o  out  5  destination index, stable while valid_o=1

## Operation
- States: IDLE, CALC, DONE.
- IDLE: busy_o=0. start_i=1 -> latch op, rd, operand magnitudes and sign flags; go to CALC with count=0, or DONE directly on fast path.
- CALC: one iteration per edge, count 0..31; after iteration 31 apply sign fix-up, register result, go to DONE.
- DONE: valid_o=1 for exactly one cycle, then IDLE.
- Multiply: 64-bit product of magnitudes; negate if signs differ. MUL -> low 32 bits; MULH/MULHSU/MULHU -> high 32. MULHSU: A signed, B unsigned.
- Divide: restoring, unsigned magnitudes. Quotient negated if signs differ (signed ops); remainder takes sign of dividend.
- Fast path (IDLE -> DONE, no CALC): divisor 0 -> DIV/DIVU result 0xFFFFFFFF, REM/REMU result a_i; DIV with a_i=0x80000000, b_i=0xFFFFFFFF -> 0x80000000, REM same case -> 0.
- rd_i=0 processed normally; rd_o=0 (discarded by register file).
- flush_i=1: next state IDLE from any state, valid_o not asserted; flush_i and start_i same cycle -> flush wins, nothing accepted.
- start_i while busy_o=1: ignored, no queueing; in-flight result unaffected.
- Operands sampled only at acceptance; later a_i/b_i changes ignored.

## Timing
- Reset (rst=0, asynchronous): state IDLE, busy_o=0, valid_o=0, result_o=0, rd_o=0, count=0.
- Start accepted at edge E0; busy_o=1 after E0.
- Normal op: CALC at E1..E32; valid_o=1 in cycle after E32 (33 cycles after E0); busy_o=0 after E33.
- Fast path: valid_o=1 in cycle after E0; busy_o=0 after E1.
- Back-to-back: new start_i accepted in first cycle with busy_o=0 (the cycle after DONE).
- result_o/rd_o hold last value after valid_o drops until next DONE.
- Reset asserted mid-operation: immediate return to reset values; no valid_o.

## Configuration
- MDU_DIV_EN defined: ops 4-7 implemented as above.
- MDU_DIV_EN undefined: divider datapath removed; ops 4-7 take fast path, result_o=0, valid_o one cycle after acceptance; multiply unchanged.

## Test plan
- MUL a=7, b=-3 (0xFFFFFFFD) -> valid_o 33 cycles after start, result 0xFFFFFFEB, rd_o=rd_i.
- MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=-1, b=2 -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
- DIV b=0, a=5 -> 0xFFFFFFFF one cycle after start; REM -> 5; DIV 0x80000000/-1 -> 0x80000000 one cycle after start (MDU_DIV_EN undefined: both 0).
- start during busy with different operands -> ignored, first result correct; flush_i at CALC count 10 -> no valid_o, busy_o=0 next cycle, new start accepted.
- rst low at CALC count 20 -> busy_o, valid_o, result_o, rd_o immediately 0; no valid_o after release.
